// File: rtl/rca_profiler_pkg.sv
// Shared op/field encodings and default parameters for the SBB profiler.
// No logic of its own.
package rca_profiler_pkg;

   typedef enum logic [1:0] {
      OP_READ        = 2'd0,
      OP_TOGGLE_LOCK = 2'd1,
      OP_CLEAR_ENTRY = 2'd2,
      OP_ACK_EXC     = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      FLD_ADDR    = 2'd0,
      FLD_VALID   = 2'd1,
      FLD_COUNT   = 2'd2,
      FLD_PENDING = 2'd3
   } field_e;

   localparam int DEF_NUM_ENTRIES    = 8;
   localparam int DEF_COUNT_W        = 8;
   localparam int DEF_THRESHOLD      = 64;
   localparam int DEF_SBB_MAX_OFFSET = -256;
   localparam int DEF_ID_W           = 3;
   localparam int DEF_AGE_PERIOD     = 4096;

endpackage

// File: rtl/rca_profiler_victim_sel.sv
// Picks the allocation victim: lowest invalid entry, else lowest-index minimum count.
// Latency: combinational; backpressure: none.
module rca_profiler_victim_sel
   import rca_profiler_pkg::*;
#(
   parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
   parameter int COUNT_W     = DEF_COUNT_W
) (
   input  logic [NUM_ENTRIES-1:0]         valid,
   input  logic [NUM_ENTRIES*COUNT_W-1:0] counts,
   output logic [$clog2(NUM_ENTRIES)-1:0] victim
);

   localparam int IDX_W = $clog2(NUM_ENTRIES);

   logic             inv_found;
   logic [IDX_W-1:0] inv_idx;
   logic [IDX_W-1:0] min_idx;
   logic [COUNT_W-1:0] min_cnt;

   always_comb begin
      inv_found = 1'b0;
      inv_idx   = '0;
      min_idx   = '0;
      min_cnt   = counts[COUNT_W-1:0];
      // Descending scan so the lowest invalid index wins.
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            inv_found = 1'b1;
            inv_idx   = IDX_W'(i);
         end
      end
      // Strict compare keeps the lowest index among equal minima.
      for (int i = 1; i < NUM_ENTRIES; i++) begin
         if (counts[i*COUNT_W +: COUNT_W] < min_cnt) begin
            min_cnt = counts[i*COUNT_W +: COUNT_W];
            min_idx = IDX_W'(i);
         end
      end
      victim = inv_found ? inv_idx : min_idx;
   end

endmodule

// File: rtl/rca_sbb_profiler_gen2.sv
// SBB loop profiler FU: hot-branch cache, threshold exceptions; result 1 cycle after accept,
// issue_ready low while wb_done held awaiting wb_ack. Aging via RCA_PROFILER_AGING_EN.
module rca_sbb_profiler_gen2
   import rca_profiler_pkg::*;
#(
   parameter int NUM_ENTRIES    = DEF_NUM_ENTRIES,
   parameter int COUNT_W        = DEF_COUNT_W,
   parameter int THRESHOLD      = DEF_THRESHOLD,
   parameter int SBB_MAX_OFFSET = DEF_SBB_MAX_OFFSET,
   parameter int ID_W           = DEF_ID_W,
   parameter int AGE_PERIOD     = DEF_AGE_PERIOD
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           br_valid,
   input  logic                           br_taken,
   input  logic [31:0]                    br_pc,
   input  logic [20:0]                    br_offset,
   input  logic                           issue_valid,
   output logic                           issue_ready,
   input  logic [ID_W-1:0]                issue_id,
   input  logic [1:0]                     issue_op,
   input  logic [$clog2(NUM_ENTRIES)-1:0] issue_entry,
   input  logic [1:0]                     issue_field,
   output logic                           wb_done,
   input  logic                           wb_ack,
   output logic [ID_W-1:0]                wb_id,
   output logic [31:0]                    wb_rd,
   output logic                           exc_valid,
   output logic [$clog2(NUM_ENTRIES)-1:0] exc_entry
);

   localparam int IDX_W = $clog2(NUM_ENTRIES);
   localparam logic [COUNT_W-1:0] CNT_MAX = '1;
   localparam logic [COUNT_W-1:0] THR     = COUNT_W'(THRESHOLD);
   localparam logic signed [20:0] SBB_LIM = 21'(SBB_MAX_OFFSET);

   typedef struct packed {
      logic [31:0]        addr;
      logic               valid;
      logic [COUNT_W-1:0] count;
   } entry_t;

   entry_t ent_q [NUM_ENTRIES];
   entry_t ent_d [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] pend_q, pend_d, hit, at_max, valid_vec;
   logic [NUM_ENTRIES*COUNT_W-1:0] count_vec;
   logic [IDX_W-1:0] victim, low_idx;
   logic locked, upd, is_sbb, alloc, sat, halve, age_tick;
   logic accept, clr_op, ack_op;
   logic signed [20:0] off_s;
   logic [31:0] rd_val;

   assign upd         = br_valid & br_taken & ~locked;
   assign off_s       = $signed(br_offset);
   assign is_sbb      = (off_s < 21'sd0) && (off_s > SBB_LIM);
   assign issue_ready = ~wb_done;
   assign accept      = issue_valid & ~wb_done;
   assign clr_op      = accept & (op_e'(issue_op) == OP_CLEAR_ENTRY);
   assign ack_op      = accept & (op_e'(issue_op) == OP_ACK_EXC);

`ifdef RCA_PROFILER_AGING_EN
   localparam int AGE_W = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;
   logic [AGE_W-1:0] age_cnt;

   assign age_tick = ~locked & (age_cnt == AGE_W'(AGE_PERIOD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         age_cnt <= '0;
      else if (!locked)
         age_cnt <= age_tick ? '0 : age_cnt + 1'b1;
   end
`else
   assign age_tick = 1'b0;
`endif

   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         valid_vec[i] = ent_q[i].valid;
         count_vec[i*COUNT_W +: COUNT_W] = ent_q[i].count;
         hit[i]    = upd & ent_q[i].valid & (ent_q[i].addr == br_pc);
         at_max[i] = (ent_q[i].count == CNT_MAX);
      end
   end

   rca_profiler_victim_sel #(
      .NUM_ENTRIES (NUM_ENTRIES),
      .COUNT_W     (COUNT_W)
   ) u_victim_sel (
      .valid  (valid_vec),
      .counts (count_vec),
      .victim (victim)
   );

   assign sat   = |(hit & at_max);
   assign halve = sat | age_tick;
   assign alloc = upd & ~(|hit) & is_sbb;

   // Software clear/ack are applied last so they win over a same-cycle branch.
   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         ent_d[i] = ent_q[i];
         if (halve)
            ent_d[i].count = ent_q[i].count >> 1;
         if (hit[i])
            ent_d[i].count = halve ? (ent_q[i].count >> 1) + 1'b1 : ent_q[i].count + 1'b1;
         pend_d[i] = pend_q[i] | ((ent_q[i].count < THR) && (ent_d[i].count >= THR));
         if (alloc && victim == IDX_W'(i)) begin
            ent_d[i]  = '{addr: br_pc, valid: 1'b1, count: COUNT_W'(1)};
            pend_d[i] = 1'b0;
         end
         if ((clr_op || ack_op) && issue_entry == IDX_W'(i))
            pend_d[i] = 1'b0;
         if (clr_op && issue_entry == IDX_W'(i))
            ent_d[i] = '0;
      end
   end

   always_comb begin
      rd_val = '0;
      if (op_e'(issue_op) == OP_READ) begin
         case (field_e'(issue_field))
            FLD_ADDR:    rd_val = ent_q[issue_entry].addr;
            FLD_VALID:   rd_val = 32'(ent_q[issue_entry].valid);
            FLD_COUNT:   rd_val = 32'(ent_q[issue_entry].count);
            FLD_PENDING: rd_val = 32'(pend_q);
            default:     rd_val = '0;
         endcase
      end
   end

   always_comb begin
      low_idx = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--)
         if (pend_q[i]) low_idx = IDX_W'(i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= '0;
         pend_q    <= '0;
         locked    <= 1'b1;
         wb_done   <= 1'b0;
         wb_id     <= '0;
         wb_rd     <= '0;
         exc_valid <= 1'b0;
         exc_entry <= '0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= ent_d[i];
         pend_q    <= pend_d;
         exc_valid <= |pend_q;
         exc_entry <= low_idx;
         if (accept && op_e'(issue_op) == OP_TOGGLE_LOCK)
            locked <= ~locked;
         if (accept) begin
            wb_done <= 1'b1;
            wb_id   <= issue_id;
            wb_rd   <= rd_val;
         end else if (wb_ack) begin
            wb_done <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rca_sbb_profiler_gen2.sv
// Directed bench for rca_sbb_profiler_gen2 with hand-computed expectations.
module tb_rca_sbb_profiler_gen2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        br_valid = 1'b0, br_taken = 1'b0;
   logic [31:0] br_pc = '0;
   logic [20:0] br_offset = '0;
   logic        issue_valid = 1'b0;
   logic        issue_ready;
   logic [2:0]  issue_id = '0;
   logic [1:0]  issue_op = '0;
   logic [2:0]  issue_entry = '0;
   logic [1:0]  issue_field = '0;
   logic        wb_done;
   logic        wb_ack = 1'b0;
   logic [2:0]  wb_id;
   logic [31:0] wb_rd;
   logic        exc_valid;
   logic [2:0]  exc_entry;

   int total = 0;
   int bad = 0;
   logic [31:0] rd;
   logic [2:0]  next_id = 3'd1;

   rca_sbb_profiler_gen2 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .br_valid    (br_valid),
      .br_taken    (br_taken),
      .br_pc       (br_pc),
      .br_offset   (br_offset),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_id    (issue_id),
      .issue_op    (issue_op),
      .issue_entry (issue_entry),
      .issue_field (issue_field),
      .wb_done     (wb_done),
      .wb_ack      (wb_ack),
      .wb_id       (wb_id),
      .wb_rd       (wb_rd),
      .exc_valid   (exc_valid),
      .exc_entry   (exc_entry)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic branch(input logic [31:0] pc, input logic [20:0] off, input int n);
      @(negedge clk);
      br_valid = 1'b1; br_taken = 1'b1; br_pc = pc; br_offset = off;
      repeat (n) @(negedge clk);
      br_valid = 1'b0; br_taken = 1'b0;
   endtask

   task automatic do_op(input logic [1:0] op, input logic [2:0] e, input logic [1:0] f,
                        output logic [31:0] res);
      int w;
      @(negedge clk);
      issue_valid = 1'b1; issue_op = op; issue_entry = e; issue_field = f; issue_id = next_id;
      @(negedge clk);
      issue_valid = 1'b0;
      w = 0;
      while (!wb_done && w < 8) begin
         @(negedge clk);
         w++;
      end
      chk("wb_done_seen", 32'(wb_done), 32'd1);
      chk("wb_id", 32'(wb_id), 32'(next_id));
      res = wb_rd;
      wb_ack = 1'b1;
      @(negedge clk);
      wb_ack = 1'b0;
      next_id = next_id + 3'd1;
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] e, input logic [1:0] f,
                         input logic [31:0] exp);
      logic [31:0] r;
      do_op(2'd0, e, f, r);
      chk(tag, r, exp);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_issue_ready", 32'(issue_ready), 32'd1);
      chk("rst_wb_done", 32'(wb_done), 32'd0);
      chk("rst_wb_id", 32'(wb_id), 32'd0);
      chk("rst_wb_rd", wb_rd, 32'd0);
      chk("rst_exc_valid", 32'(exc_valid), 32'd0);
      chk("rst_exc_entry", 32'(exc_entry), 32'd0);
      rd_chk("rst_cnt0", 3'd0, 2'd2, 32'd0);

      // Reset leaves the unit locked: no allocation.
      branch(32'h100, -21'sd16, 1);
      rd_chk("locked_valid0", 3'd0, 2'd1, 32'd0);
      do_op(2'd1, 3'd0, 2'd0, rd);
      chk("toggle_ret", rd, 32'd0);

      branch(32'h100, -21'sd16, 3);
      rd_chk("cnt0_eq3", 3'd0, 2'd2, 32'd3);
      rd_chk("valid0", 3'd0, 2'd1, 32'd1);
      rd_chk("addr0", 3'd0, 2'd0, 32'h100);

      branch(32'h200, -21'sd300, 1);
      rd_chk("far_no_alloc", 3'd1, 2'd1, 32'd0);
      branch(32'h204, -21'sd256, 1);
      rd_chk("lim_no_alloc", 3'd1, 2'd1, 32'd0);
      branch(32'h208, -21'sd255, 1);
      rd_chk("lim1_alloc", 3'd1, 2'd0, 32'h208);
      branch(32'h20C, 21'sd16, 1);
      rd_chk("fwd_no_alloc", 3'd2, 2'd1, 32'd0);

      // Fresh state: fill entries with counts 1..8.
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      do_op(2'd1, 3'd0, 2'd0, rd);
      for (int i = 0; i < 8; i++) branch(32'h1000 + 32'(i * 16), -21'sd8, i + 1);
      rd_chk("fill_cnt7", 3'd7, 2'd2, 32'd8);
      rd_chk("fill_cnt3", 3'd3, 2'd2, 32'd4);
      branch(32'h900, -21'sd8, 1);
      rd_chk("evict_addr0", 3'd0, 2'd0, 32'h900);
      rd_chk("evict_cnt0", 3'd0, 2'd2, 32'd1);
      rd_chk("keep_cnt1", 3'd1, 2'd2, 32'd2);

      // Entry 2: 3 -> 63, then the crossing hit.
      branch(32'h1020, -21'sd8, 60);
      rd_chk("pend_before", 3'd0, 2'd3, 32'd0);
      @(negedge clk);
      br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h1020; br_offset = -21'sd8;
      @(negedge clk);
      br_valid = 1'b0; br_taken = 1'b0;
      chk("exc_lat1", 32'(exc_valid), 32'd0);
      @(negedge clk);
      chk("exc_lat2", 32'(exc_valid), 32'd1);
      chk("exc_entry2", 32'(exc_entry), 32'd2);
      rd_chk("pend_04", 3'd0, 2'd3, 32'h4);
      rd_chk("cnt2_64", 3'd2, 2'd2, 32'd64);
      do_op(2'd3, 3'd2, 2'd0, rd);
      chk("ack_ret", rd, 32'd0);
      chk("ack_exc_valid", 32'(exc_valid), 32'd0);
      branch(32'h1020, -21'sd8, 1);
      rd_chk("no_retrigger", 3'd0, 2'd3, 32'd0);

      // Saturation: entry 1 to 255, entry 3 to 10, then one more hit on entry 1.
      branch(32'h1010, -21'sd8, 253);
      rd_chk("cnt1_255", 3'd1, 2'd2, 32'd255);
      chk("exc_entry1", 32'(exc_entry), 32'd1);
      branch(32'h1030, -21'sd8, 6);
      branch(32'h1010, -21'sd8, 1);
      rd_chk("sat_cnt1", 3'd1, 2'd2, 32'd128);
      rd_chk("sat_cnt3", 3'd3, 2'd2, 32'd5);
      rd_chk("sat_cnt2", 3'd2, 2'd2, 32'd32);
      rd_chk("sat_cnt0", 3'd0, 2'd2, 32'd0);
      rd_chk("sat_cnt7", 3'd7, 2'd2, 32'd4);
      rd_chk("sat_pend", 3'd0, 2'd3, 32'h2);
      branch(32'h1020, -21'sd8, 32);
      rd_chk("rearm_pend", 3'd0, 2'd3, 32'h6);

      do_op(2'd2, 3'd1, 2'd0, rd);
      chk("clr_ret", rd, 32'd0);
      rd_chk("clr_valid1", 3'd1, 2'd1, 32'd0);
      rd_chk("clr_cnt1", 3'd1, 2'd2, 32'd0);
      rd_chk("clr_addr1", 3'd1, 2'd0, 32'd0);
      rd_chk("clr_pend", 3'd0, 2'd3, 32'h4);
      chk("clr_exc_entry", 32'(exc_entry), 32'd2);
      // Invalid entry 1 beats entry 0 whose count is 0.
      branch(32'hA00, -21'sd8, 1);
      rd_chk("victim_inv", 3'd1, 2'd0, 32'hA00);

      do_op(2'd1, 3'd0, 2'd0, rd);
      branch(32'h1030, -21'sd8, 1);
      rd_chk("locked_cnt3", 3'd3, 2'd2, 32'd5);

      // Hold the result without ack, then reset mid-wait.
      @(negedge clk);
      issue_valid = 1'b1; issue_op = 2'd0; issue_entry = 3'd3; issue_field = 2'd0;
      issue_id = 3'd5;
      @(negedge clk);
      issue_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("hold_done", 32'(wb_done), 32'd1);
         chk("hold_rd", wb_rd, 32'h1030);
         chk("hold_ready", 32'(issue_ready), 32'd0);
         @(negedge clk);
      end
      chk("hold_id", 32'(wb_id), 32'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_done", 32'(wb_done), 32'd0);
      chk("mid_rst_ready", 32'(issue_ready), 32'd1);
      chk("mid_rst_exc", 32'(exc_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wb_ack = 1'b1;
      @(negedge clk);
      wb_ack = 1'b0;
      chk("stray_ack", 32'(wb_done), 32'd0);
      rd_chk("post_rst_valid3", 3'd3, 2'd1, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
